// File: rtl/audio_out_pkg.sv
// Shared types and constants for the I2S audio output block.
// SAMPLE_W fixes the sample width carried by stereo_pair_t and the upstream interface.
package audio_out_pkg;

  localparam int SAMPLE_W = 24;
  localparam logic [8:0] GAIN_UNITY = 9'd256;

  typedef struct packed {
    logic signed [SAMPLE_W-1:0] l;
    logic signed [SAMPLE_W-1:0] r;
  } stereo_pair_t;

  function automatic int frame_w(input int slot_w);
    return 2 * slot_w;
  endfunction

endpackage

// File: rtl/audio_out_i2s_if.sv
// Upstream sample handshake: the mixer (master) offers stereo pairs,
// the I2S output block (slave) accepts them when sample_ready is high.
interface audio_out_i2s_if;
  import audio_out_pkg::*;

  logic                       sample_valid;
  logic                       sample_ready;
  logic signed [SAMPLE_W-1:0] lsound_in;
  logic signed [SAMPLE_W-1:0] rsound_in;

  modport master (
    output sample_valid,
    output lsound_in,
    output rsound_in,
    input  sample_ready
  );

  modport slave (
    input  sample_valid,
    input  lsound_in,
    input  rsound_in,
    output sample_ready
  );

endinterface

// File: rtl/stereo_sample_fifo.sv
// Synchronous FIFO of stereo pairs; level and full are registered so the
// upstream ready is a clean flop output. DEPTH must be a power of two >= 2.
module stereo_sample_fifo
  import audio_out_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_push,
  input  stereo_pair_t              i_data,
  input  logic                      i_pop,
  output stereo_pair_t              o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  stereo_pair_t    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [LW-1:0]   r_level;
  logic            r_full;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic [LW-1:0]   w_level_nxt;

  // Qualify requests against the registered state.
  always_comb begin
    w_empty = (r_level == '0);
    w_push  = i_push & ~r_full;
    w_pop   = i_pop & ~w_empty;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + LW'(1);
      2'b01:   w_level_nxt = r_level - LW'(1);
      default: w_level_nxt = r_level;
    endcase
  end

  // Pointers, level and full flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LW'(DEPTH));
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = w_empty;
  assign o_level = r_level;

endmodule

// File: rtl/audio_out_i2s.sv
// I2S serialiser fed by a small stereo FIFO; BCLK/LRCLK come from clock-enable
// division of the system clock. Optional SOFT_MUTE_EN adds a mute input and gain ramp.
module audio_out_i2s
  import audio_out_pkg::*;
#(
  parameter int AUDIO_W    = SAMPLE_W,
  parameter int SLOT_W     = 32,
  parameter int BCLK_DIV   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sCLK_XVXENVS,
  input  logic                          reset_data,
  audio_out_i2s_if.slave                up,
  output logic                          i2s_bclk,
  output logic                          i2s_lrclk,
  output logic                          i2s_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    underrun_cnt
`ifdef SOFT_MUTE_EN
  ,
  input  logic                          mute
`endif
);

  localparam int FRAME_W = frame_w(SLOT_W);
  localparam int BW      = $clog2(FRAME_W);
  localparam int DW      = $clog2(BCLK_DIV);

  logic [DW-1:0]          r_div_cnt;
  logic [BW-1:0]          r_bit_cnt;
  logic [FRAME_W-1:0]     r_shift;
  logic                   r_bclk;
  logic                   r_lrclk;
  logic                   r_data;
  logic [7:0]             r_underrun;

  logic [DW-1:0]          w_div_nxt;
  logic [BW-1:0]          w_bit_nxt;
  logic                   w_fall;
  logic                   w_load;
  logic [FRAME_W-1:0]     w_frame;
  logic signed [AUDIO_W-1:0] w_left;
  logic signed [AUDIO_W-1:0] w_right;

  stereo_pair_t           w_push_pair;
  stereo_pair_t           w_head;
  logic                   w_fifo_full;
  logic                   w_fifo_empty;

  assign w_push_pair     = {up.lsound_in, up.rsound_in};
  assign up.sample_ready = ~w_fifo_full;

  stereo_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (sCLK_XVXENVS),
    .rst     (reset_data),
    .i_push  (up.sample_valid),
    .i_data  (w_push_pair),
    .i_pop   (w_load),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (fifo_level)
  );

  // Divider and bit-position next-state; a frame loads on the last bit's fall event.
  always_comb begin
    w_fall = (r_div_cnt == DW'(BCLK_DIV - 1));
    w_load = w_fall && (r_bit_cnt == BW'(FRAME_W - 1));
    if (w_fall) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div_cnt + DW'(1);
    end
    if (w_load) begin
      w_bit_nxt = '0;
    end else if (w_fall) begin
      w_bit_nxt = r_bit_cnt + BW'(1);
    end else begin
      w_bit_nxt = r_bit_cnt;
    end
  end

`ifdef SOFT_MUTE_EN
  logic [8:0] r_gain;
  logic [8:0] w_gain_nxt;

  function automatic logic signed [AUDIO_W-1:0] scale(
    input logic signed [AUDIO_W-1:0] s,
    input logic [8:0]                g
  );
    logic signed [AUDIO_W+9:0] p;
    p = s * $signed({1'b0, g});
    return p[AUDIO_W+7:8];
  endfunction

  // One gain step per frame; the stepped gain applies to the frame being loaded.
  always_comb begin
    if (mute) begin
      if (r_gain != 9'd0) begin
        w_gain_nxt = r_gain - 9'd1;
      end else begin
        w_gain_nxt = r_gain;
      end
    end else begin
      if (r_gain != GAIN_UNITY) begin
        w_gain_nxt = r_gain + 9'd1;
      end else begin
        w_gain_nxt = r_gain;
      end
    end
    w_left  = scale(w_head.l, w_gain_nxt);
    w_right = scale(w_head.r, w_gain_nxt);
  end

  // Gain register, updated only at frame boundaries.
  always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
    if (reset_data) begin
      r_gain <= GAIN_UNITY;
    end else if (w_load) begin
      r_gain <= w_gain_nxt;
    end
  end
`else
  assign w_left  = w_head.l;
  assign w_right = w_head.r;
`endif

  // Frame word: left slot then right slot, each sample left-justified, zero padded.
  always_comb begin
    w_frame = '0;
    if (!w_fifo_empty) begin
      w_frame[FRAME_W-1 -: AUDIO_W] = w_left;
      w_frame[SLOT_W-1 -: AUDIO_W]  = w_right;
    end else begin
      w_frame = '0;
    end
  end

  // Clock generation, serial shifter and underrun counter; all outputs move on the fall event.
  always_ff @(posedge sCLK_XVXENVS or posedge reset_data) begin
    if (reset_data) begin
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_bclk     <= 1'b0;
      r_lrclk    <= 1'b0;
      r_data     <= 1'b0;
      r_underrun <= 8'd0;
    end else begin
      r_div_cnt <= w_div_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_bclk    <= (w_div_nxt >= DW'(BCLK_DIV / 2));
      r_lrclk   <= (w_bit_nxt >= BW'(SLOT_W));
      // The old frame's last bit goes out during bit 0, giving the I2S one-bit delay.
      if (w_load) begin
        r_data  <= r_shift[FRAME_W-1];
        r_shift <= w_frame;
      end else if (w_fall) begin
        r_data  <= r_shift[FRAME_W-1];
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
      end
      if (w_load && w_fifo_empty && (r_underrun != 8'hFF)) begin
        r_underrun <= r_underrun + 8'd1;
      end
    end
  end

  assign i2s_bclk     = r_bclk;
  assign i2s_lrclk    = r_lrclk;
  assign i2s_data     = r_data;
  assign underrun_cnt = r_underrun;

endmodule

// File: tb/tb_audio_out_i2s.sv
// Directed bench for audio_out_i2s (SLOT_W=32, BCLK_DIV=4: one frame = 256 clocks).
module tb_audio_out_i2s;
  import audio_out_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bclk;
  logic        lrclk;
  logic        sdata;
  logic [2:0]  level;
  logic [7:0]  urun;
  int          cyc;
  int          checks;
  int          errors;
  logic        data_seen;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [63:0] frame;
  } vec_t;

  vec_t vecs [5];

  audio_out_i2s_if u_if ();

  audio_out_i2s #(
    .AUDIO_W    (24),
    .SLOT_W     (32),
    .BCLK_DIV   (4),
    .FIFO_DEPTH (4)
  ) dut (
    .sCLK_XVXENVS (clk),
    .reset_data   (rst),
    .up           (u_if.slave),
    .i2s_bclk     (bclk),
    .i2s_lrclk    (lrclk),
    .i2s_data     (sdata),
    .fifo_level   (level),
    .underrun_cnt (urun)
`ifdef SOFT_MUTE_EN
    ,
    .mute         (1'b0)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic run_watch(input int n);
    while (cyc < n) begin
      step();
      data_seen = data_seen | sdata;
    end
  endtask

  task automatic push(input logic [23:0] l, input logic [23:0] r);
    u_if.sample_valid = 1'b1;
    u_if.lsound_in    = l;
    u_if.rsound_in    = r;
    step();
    u_if.sample_valid = 1'b0;
  endtask

  // Frame f loads at clock 256*f; bit k is sampled one clock into its BCLK period.
  task automatic capture(input int f, output logic [63:0] d, output logic [63:0] lr,
                         output logic [63:0] bc);
    d  = '0;
    lr = '0;
    bc = '0;
    for (int k = 1; k <= 64; k++) begin
      run_to(256 * f + 4 * k + 1);
      d  = {d[62:0], sdata};
      lr = {lr[62:0], lrclk};
      run_to(256 * f + 4 * k + 3);
      bc = {bc[62:0], bclk};
    end
  endtask

  initial begin
    logic [63:0] d, lr, bc;
    checks = 0;
    errors = 0;
    cyc    = 0;
    data_seen = 1'b0;
    vecs[0] = '{24'h800001, 24'h7FFFFE, 64'h80000100_7FFFFE00};
    vecs[1] = '{24'h123456, 24'hABCDEF, 64'h12345600_ABCDEF00};
    vecs[2] = '{24'hFFFFFF, 24'h000000, 64'hFFFFFF00_00000000};
    vecs[3] = '{24'h000001, 24'h800000, 64'h00000100_80000000};
    vecs[4] = '{24'h555555, 24'hAAAAAA, 64'h55555500_AAAAAA00};

    rst = 1'b1;
    u_if.sample_valid = 1'b0;
    u_if.lsound_in    = 24'h000000;
    u_if.rsound_in    = 24'h000000;
    repeat (2) @(negedge clk);
    check("rst_bclk", 64'(bclk), 64'd0);
    check("rst_lrclk", 64'(lrclk), 64'd0);
    check("rst_data", 64'(sdata), 64'd0);
    check("rst_ready", 64'(u_if.sample_ready), 64'd1);
    check("rst_level", 64'(level), 64'd0);
    check("rst_underrun", 64'(urun), 64'd0);
    rst = 1'b0;
    cyc = 0;

    // Idle frames: silent output, underruns counted from the first load onward.
    run_watch(5);
    check("first_left_slot", 64'(lrclk), 64'd0);
    run_watch(129);
    check("first_right_slot", 64'(lrclk), 64'd1);
    run_watch(255);
    check("underrun_before_load", 64'(urun), 64'd0);
    run_watch(769);
    check("idle_data_zero", 64'(data_seen), 64'd0);
    check("underrun_3", 64'(urun), 64'd3);

    // Table: each pair pushed into an empty FIFO, sent in the following frame.
    for (int i = 0; i < 5; i++) begin
      int f;
      f = 4 + 2 * i;
      run_to(256 * (f - 1) + 1);
      push(vecs[i].l, vecs[i].r);
      check($sformatf("level_after_push[%0d]", i), 64'(level), 64'd1);
      capture(f, d, lr, bc);
      check($sformatf("frame_data[%0d]", i), d, vecs[i].frame);
      check($sformatf("frame_lrclk[%0d]", i), lr, 64'h00000001_FFFFFFFE);
      check($sformatf("frame_bclk[%0d]", i), bc, 64'hFFFFFFFF_FFFFFFFF);
    end
    run_to(3330);
    check("underrun_after_table", 64'(urun), 64'd8);

    // Back-pressure: valid held high with no frame boundary.
    u_if.sample_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      u_if.lsound_in = 24'hA00000 | 24'(j);
      u_if.rsound_in = 24'h0B0000 | 24'(j);
      step();
    end
    u_if.sample_valid = 1'b0;
    check("bp_level_full", 64'(level), 64'd4);
    check("bp_ready_low", 64'(u_if.sample_ready), 64'd0);
    run_to(3585);
    check("bp_level_after_pop", 64'(level), 64'd3);
    check("bp_ready_after_pop", 64'(u_if.sample_ready), 64'd1);
    capture(14, d, lr, bc);
    check("bp_frame0", d, 64'hA0000000_0B000000);
    capture(15, d, lr, bc);
    check("bp_frame1", d, 64'hA0000100_0B000100);

    // Push on the exact frame-load clock with the FIFO empty.
    run_to(4607);
    check("sim_level_before", 64'(level), 64'd0);
    push(24'h00F00F, 24'hFFF000);
    check("sim_underrun", 64'(urun), 64'd9);
    check("sim_level", 64'(level), 64'd1);
    capture(19, d, lr, bc);
    check("sim_frame", d, 64'h00F00F00_FFF00000);
    check("sim_level_drained", 64'(level), 64'd0);
    check("sim_underrun_next", 64'(urun), 64'd10);

    // Mid-frame asynchronous reset.
    push(24'hFFFFFF, 24'hFFFFFF);
    push(24'h123456, 24'h654321);
    run_to(5400);
    check("pre_reset_data", 64'(sdata), 64'd1);
    check("pre_reset_level", 64'(level), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bclk", 64'(bclk), 64'd0);
    check("mid_rst_lrclk", 64'(lrclk), 64'd0);
    check("mid_rst_data", 64'(sdata), 64'd0);
    check("mid_rst_ready", 64'(u_if.sample_ready), 64'd1);
    check("mid_rst_level", 64'(level), 64'd0);
    check("mid_rst_underrun", 64'(urun), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    data_seen = 1'b0;

    // Restart from the left slot, partial frame discarded, then saturate the counter.
    run_watch(5);
    check("post_rst_left", 64'(lrclk), 64'd0);
    run_watch(129);
    check("post_rst_right", 64'(lrclk), 64'd1);
    run_watch(255);
    check("post_rst_data_zero", 64'(data_seen), 64'd0);
    check("post_rst_underrun0", 64'(urun), 64'd0);
    run_to(257);
    check("post_rst_underrun1", 64'(urun), 64'd1);
    run_to(65279);
    check("underrun_254", 64'(urun), 64'd254);
    run_to(65281);
    check("underrun_255", 64'(urun), 64'd255);
    run_to(66049);
    check("underrun_saturated", 64'(urun), 64'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
